key_poll_master: RTL and testbench
==================================

KEY_POLL_MASTER -- requirements
Module: key_poll_master

Interface
REQ-001 The block SHALL have parameter POLL_DIV, default 50000, meaning clock cycles between successive polls (minimum 4).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; port clk, input, 1, rising-edge clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port avm_address, output, 2, Avalon-MM address, constant 0 (data register of the key PIO).
REQ-006 The block SHALL have port avm_read, output, 1, Avalon-MM read request.
REQ-007 The block SHALL have port avm_waitrequest, input, 1, slave stall; the read is held while high.
REQ-008 The block SHALL have port avm_readdata, input, 32, read data; only bits [1:0] are used.
REQ-009 The block SHALL have port evt_valid, output, 1, high when the event FIFO is non-empty.
REQ-010 The block SHALL have port evt_ready, input, 1, consumer accepts the head event.
REQ-011 The block SHALL have port evt_data, output, 4, head event: [3:2] new key state, [1:0] changed-key mask.
REQ-012 The block SHALL have port key_state, output, 2, current accepted key state.
REQ-013 The block SHALL have port overflow, output, 1, sticky: an event was dropped.

Function
REQ-014 The FSM SHALL have states IDLE, READ, CAPTURE and PROC.
REQ-015 On entry to IDLE, the poll counter SHALL load POLL_DIV-1, then decrement each cycle; at 0 the FSM SHALL go to READ.
REQ-016 In READ, avm_read SHALL be 1; on a cycle with avm_waitrequest=0, the read is accepted and the FSM SHALL go to CAPTURE.
REQ-017 avm_read SHALL be 0 in every state except READ, and avm_address SHALL always be 0.
REQ-018 In CAPTURE (fixed read latency 1), the block SHALL register avm_readdata[1:0] as sample and go to PROC.
REQ-019 In PROC, the block SHALL compute the accepted state per REQ-031/032; if it differs from key_state, key_state SHALL update and event {new, new XOR old} SHALL be pushed; the FSM SHALL then return to IDLE.
REQ-020 The poll period SHALL be POLL_DIV + 3 + (number of waitrequest stall cycles) clocks.
REQ-021 At most one event SHALL be pushed per poll; simultaneous changes of both keys SHALL give a single event with mask 2'b11.
REQ-022 Pop SHALL occur when evt_valid=1 and evt_ready=1; evt_data SHALL be 0 when the FIFO is empty.
REQ-023 A push to a full FIFO SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case both SHALL take effect and the count SHALL be unchanged.
REQ-024 A push and a pop on a non-empty, non-full FIFO in the same cycle SHALL leave the count unchanged and preserve order.
REQ-025 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 overflow SHALL remain 1 until reset.

Reset
REQ-027 Reset SHALL put the FSM in IDLE with the counter loaded to POLL_DIV-1, so the first avm_read occurs POLL_DIV cycles after reset deasserts.
REQ-028 Reset SHALL set avm_read=0, evt_valid=0, evt_data=0, overflow=0, key_state=2'b11 (keys released, active-low), FIFO empty and debounce state cleared.
REQ-029 Reset asserted mid-transaction (READ, CAPTURE or PROC) SHALL abort it on the next edge, with no event pushed and avm_read=0 from the following cycle.
REQ-030 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-031 With macro KEY_POLL_DEBOUNCE_EN defined, a sample SHALL become the accepted state only after 3 consecutive polls return the same value differing from key_state; any differing sample SHALL restart the count.
REQ-032 Without KEY_POLL_DEBOUNCE_EN, each poll's sample SHALL be the accepted state directly, and no debounce registers SHALL exist.

Verification
REQ-033 POLL_DIV=4, waitrequest=0, readdata=3: avm_read pulses 1 cycle every 7 cycles, first pulse at cycle 4 after reset; no events.
REQ-034 waitrequest held high 5 cycles during READ: avm_read stays high 6 cycles; sample is captured only after acceptance.
REQ-035 Without debounce, readdata 3->2: one event evt_data=4'b1001 and key_state=2'b10; then 2->1 gives evt_data=4'b0111.
REQ-036 With KEY_POLL_DEBOUNCE_EN, readdata sequence 2,3,2,2,2: a single event 4'b1001 after the fifth poll, not before.
REQ-037 FIFO_DEPTH=4, evt_ready=0, 5 alternating changes: 4 events held, overflow=1; then evt_ready=1 drains the events in push order.
REQ-038 Reset asserted during CAPTURE with changed data: no event, key_state=2'b11, avm_read=0.

Source files
------------

// File: rtl/key_poll_master.sv
// Avalon-MM master that polls a two-key PIO, tracks the accepted key state and queues change events.
// Define KEY_POLL_DEBOUNCE_EN to require 3 matching polls before a new key state is accepted.
module key_poll_master #(
  parameter int unsigned POLL_DIV   = 50000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_data,
  output logic [1:0]  key_state,
  output logic        overflow
);

  localparam int unsigned CntW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(POLL_DIV - 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRead    = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StProc    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sample_q, sample_d;
  logic [1:0]      key_q, key_d;
  logic [1:0]      accepted;
  logic            push;
  logic [3:0]      push_data;

  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            ovf_q;
  logic            pop, full, wr_en;

  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    key_d    = key_q;
    push     = 1'b0;
    case (state_q)
      StIdle: begin
        if (cnt_q == '0) state_d = StRead;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StRead: begin
        if (!avm_waitrequest) state_d = StCapture;
      end
      StCapture: begin
        sample_d = avm_readdata[1:0];
        state_d  = StProc;
      end
      StProc: begin
        if (accepted != key_q) begin
          key_d = accepted;
          push  = 1'b1;
        end
        state_d = StIdle;
        cnt_d   = CntLoad;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = CntLoad;
      end
    endcase
  end

  assign push_data = {accepted, accepted ^ key_q};

`ifdef KEY_POLL_DEBOUNCE_EN
  logic [1:0] cand_q, cand_d;
  logic [1:0] run_q, run_d;

  // run_q counts consecutive polls of cand_q that differ from the accepted state
  always_comb begin
    cand_d   = cand_q;
    run_d    = run_q;
    accepted = key_q;
    if (state_q == StProc) begin
      if (sample_q == key_q) begin
        run_d = 2'd0;
      end else if (run_q != 2'd0 && sample_q == cand_q) begin
        if (run_q == 2'd2) begin
          accepted = sample_q;
          run_d    = 2'd0;
        end else begin
          run_d = run_q + 2'd1;
        end
      end else begin
        cand_d = sample_q;
        run_d  = 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= 2'b11;
      run_q  <= 2'd0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
    end
  end
`else
  assign accepted = sample_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= CntLoad;
      sample_q <= 2'b11;
      key_q    <= 2'b11;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      key_q    <= key_d;
    end
  end

  // A push into a full FIFO still lands when the head is popped in the same cycle
  assign pop   = evt_valid & evt_ready;
  assign full  = (count_q == FifoFull);
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push & full & ~pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign avm_address = 2'b00;
  assign avm_read    = (state_q == StRead);
  assign evt_valid   = (count_q != '0);
  assign evt_data    = evt_valid ? mem_q[rd_ptr_q] : 4'h0;
  assign key_state   = key_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_key_poll_master.sv
// Directed-plus-random bench for key_poll_master against a poll-level model of keys, events and FIFO.
module tb_key_poll_master;

  localparam int unsigned PollDiv = 4;
  localparam int unsigned Depth   = 4;
`ifdef KEY_POLL_DEBOUNCE_EN
  localparam int Rep = 3;
`else
  localparam int Rep = 1;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_data;
  logic [1:0]  key_state;
  logic        overflow;

  key_poll_master #(
    .POLL_DIV   (PollDiv),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_data        (evt_data),
    .key_state       (key_state),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] fifo_m [$];
  logic [1:0] hist_m [$];
  logic [1:0] key_m;
  logic       ovf_m;
  bit         rand_rdy;
  bit         proc_pop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the negedge, apply the model's pop/push for the coming edge.
  task automatic tick(input bit push, input logic [3:0] d);
    bit was_full;
    bit popped;
    if (rand_rdy) evt_ready = 1'($urandom_range(0, 1));
    chk("evt_valid", 32'(evt_valid), 32'(fifo_m.size() != 0));
    chk("evt_data", 32'(evt_data), (fifo_m.size() != 0) ? 32'(fifo_m[0]) : 32'h0);
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("key_state", 32'(key_state), 32'(key_m));
    chk("avm_address", 32'(avm_address), 32'h0);
    was_full = (fifo_m.size() == Depth);
    popped   = evt_ready && (fifo_m.size() != 0);
    if (popped) void'(fifo_m.pop_front());
    if (push) begin
      if (was_full && !popped) ovf_m = 1'b1;
      else                     fifo_m.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic wait_read();
    int n;
    n = 0;
    while (!avm_read && n < int'(PollDiv) + 8) begin
      tick(1'b0, 4'h0);
      n++;
    end
    chk("poll_gap", 32'(n), 32'(PollDiv));
    chk("read_start", 32'(avm_read), 32'h1);
  endtask

  task automatic poll(input logic [1:0] v, input int stalls);
    logic [1:0] acc;
    bit         ch;
    logic [3:0] d;
    avm_waitrequest = (stalls > 0);
    avm_readdata = $urandom();
    avm_readdata[1:0] = ~v;
    wait_read();
    for (int i = 0; i < stalls; i++) begin
      tick(1'b0, 4'h0);
      chk("read_stall", 32'(avm_read), 32'h1);
      if (i == stalls - 1) avm_waitrequest = 1'b0;
    end
    tick(1'b0, 4'h0);
    chk("read_pulse_end", 32'(avm_read), 32'h0);
    // Only the capture cycle carries the real sample
    avm_readdata = $urandom();
    avm_readdata[1:0] = v;
    tick(1'b0, 4'h0);
    avm_readdata[1:0] = ~v;
`ifdef KEY_POLL_DEBOUNCE_EN
    hist_m.push_back(v);
    if (hist_m.size() > 3) void'(hist_m.pop_front());
    acc = (hist_m.size() == 3 && hist_m[0] == v && hist_m[1] == v && v != key_m) ? v : key_m;
`else
    acc = v;
`endif
    ch = (acc != key_m);
    d  = {acc, acc ^ key_m};
    if (proc_pop) evt_ready = 1'b1;
    tick(ch, d);
    key_m = acc;
    chk("key_after_poll", 32'(key_state), 32'(key_m));
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    evt_ready = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rst_read", 32'(avm_read), 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_data", 32'(evt_data), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_key", 32'(key_state), 32'h3);
    chk("rst_address", 32'(avm_address), 32'h0);
    fifo_m.delete();
    hist_m.delete();
    key_m = 2'b11;
    ovf_m = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    evt_ready = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h3;
    rand_rdy = 1'b0;
    proc_pop = 1'b0;
    key_m = 2'b11;
    ovf_m = 1'b0;
    apply_reset(2);

    repeat (3) poll(2'b11, 0);
    poll(2'b11, 5);

    evt_ready = 1'b1;
    repeat (Rep) poll(2'b10, 0);
    repeat (Rep) poll(2'b01, 0);
    poll(2'b01, 0);

    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) repeat (Rep) poll((i % 2 == 0) ? 2'b10 : 2'b01, 0);
    chk("overflow_sticky", 32'(overflow), 32'h1);
    evt_ready = 1'b1;
    repeat (2) poll(key_m, 0);

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) poll(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    rand_rdy = 1'b0;

    // Fill the FIFO, then push into it while popping on the same edge
    evt_ready = 1'b1;
    repeat (2) poll(key_m, 0);
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) repeat (Rep) poll(~key_m, 0);
    repeat (Rep - 1) poll(~key_m, 0);
    proc_pop = 1'b1;
    poll(~key_m, 0);
    proc_pop = 1'b0;
    evt_ready = 1'b1;
    repeat (2) poll(key_m, 0);

    // Reset during CAPTURE with changed data
    evt_ready = 1'b0;
    repeat (Rep) poll(2'b00, 0);
    avm_waitrequest = 1'b0;
    avm_readdata = {30'h0, key_m};
    wait_read();
    tick(1'b0, 4'h0);
    avm_readdata = {30'h0, 2'b01};
    apply_reset(1);
    repeat (2) poll(2'b11, 0);

    foreach (hist_m[i]) hist_m[i] = hist_m[i];
    poll(2'b10, 0);
    poll(2'b11, 0);
    repeat (3) poll(2'b10, 0);
    evt_ready = 1'b1;
    poll(key_m, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
